// File: rtl/xgmii_pkg.sv
// Shared XGMII control-character codes and frame-monitor state encoding.
package xgmii_pkg;

   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERROR = 8'hFE;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } state_t;

endpackage

// File: rtl/xgmii_lane_decode.sv
// Combinational decode of one 8-lane XGMII word: first control lane and start positions.
module xgmii_lane_decode
   import xgmii_pkg::*;
(
   input  logic [63:0] rxd,
   input  logic [7:0]  rxc,
   output logic        any_ctrl,
   output logic [2:0]  first_ctrl_lane,
   output logic        first_is_term,
   output logic        first_is_error,
   output logic        start_l0,
   output logic        start_l4
);

   logic [7:0] first_byte;

   // Lane 0 is first on the wire, so the lowest set rxc bit wins.
   always_comb begin
      first_ctrl_lane = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rxc[i]) first_ctrl_lane = 3'(i);
      end
   end

   assign first_byte     = rxd[{first_ctrl_lane, 3'b000} +: 8];
   assign any_ctrl       = |rxc;
   assign first_is_term  = any_ctrl && (first_byte == XGMII_TERM);
   assign first_is_error = any_ctrl && (first_byte == XGMII_ERROR);
   assign start_l0       = rxc[0] && (rxd[7:0] == XGMII_START);
   assign start_l4       = rxc[4] && (rxd[39:32] == XGMII_START) && (&rxc[3:0]);

endmodule

// File: rtl/xgmii_rx_frame_monitor.sv
// XGMII receive frame monitor: delimits frames, measures length, classifies and counts them.
module xgmii_rx_frame_monitor
   import xgmii_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int MIN_LEN    = 64,
   parameter int MAX_LEN    = 1518,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  rx_clk,
   input  logic                  rx_rst_n,
   input  logic [DATA_WIDTH-1:0] xgmii_rxd,
   input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
   input  logic                  clr_stats,
   output logic                  frame_done,
   output logic [15:0]           frame_len,
   output logic                  frame_good,
   output logic                  frame_err,
   output logic                  in_frame,
   output logic [CNT_WIDTH-1:0]  frame_count,
   output logic [CNT_WIDTH-1:0]  bad_count
);

   localparam logic [15:0] MIN_L = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L = 16'(MAX_LEN);

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic       any_ctrl, first_is_term, first_is_error, start_l0, start_l4;
   logic [2:0] first_ctrl_lane;

   xgmii_lane_decode u_decode (
      .rxd             (xgmii_rxd),
      .rxc             (xgmii_rxc),
      .any_ctrl        (any_ctrl),
      .first_ctrl_lane (first_ctrl_lane),
      .first_is_term   (first_is_term),
      .first_is_error  (first_is_error),
      .start_l0        (start_l0),
      .start_l4        (start_l4)
   );

   state_t      state, nstate;
   logic [15:0] cnt, ncnt, cnt_fin, len_c;
   logic        close_c, err_c, good_c, b2b;

   // A frame ending in lanes 0-3 may be followed by a new Start in lane 4 of the same word.
   assign b2b = (xgmii_rxc[7:4] == 4'b0001) && (xgmii_rxd[39:32] == XGMII_START)
                && !first_ctrl_lane[2];

   always_comb begin
      nstate  = state;
      ncnt    = cnt;
      close_c = 1'b0;
      cnt_fin = sat_add16(cnt, {13'd0, first_ctrl_lane});
      case (state)
         ST_IDLE: begin
            if (start_l0) begin
               nstate = ST_FRAME;
               ncnt   = 16'd7;
            end else if (start_l4) begin
               nstate = ST_FRAME;
               ncnt   = 16'd3;
            end
         end
         ST_FRAME: begin
            if (!any_ctrl) begin
               ncnt = sat_add16(cnt, 16'd8);
            end else begin
               close_c = 1'b1;
               nstate  = b2b ? ST_FRAME : ST_IDLE;
               ncnt    = b2b ? 16'd3 : 16'd0;
            end
         end
         default: nstate = ST_IDLE;
      endcase
      len_c  = (cnt_fin >= 16'd7) ? cnt_fin - 16'd7 : 16'd0;
      // Explicit Error, or any other non-Terminate control, ends the frame in error.
      err_c  = first_is_error || !first_is_term;
      good_c = !err_c && (len_c >= MIN_L) && (len_c <= MAX_L);
   end

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         frame_done  <= 1'b0;
         frame_len   <= '0;
         frame_good  <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
         bad_count   <= '0;
      end else begin
         state      <= nstate;
         cnt        <= ncnt;
         frame_done <= close_c;
         if (close_c) begin
            frame_len  <= len_c;
            frame_good <= good_c;
            frame_err  <= err_c;
         end
         // A clear coinciding with a close still records that close.
         if (clr_stats) begin
            frame_count <= CNT_WIDTH'(close_c);
            bad_count   <= CNT_WIDTH'(close_c && !good_c);
         end else if (close_c) begin
            frame_count <= sat_inc(frame_count);
            if (!good_c) bad_count <= sat_inc(bad_count);
         end
      end
   end

   assign in_frame = (state == ST_FRAME);

endmodule
